regfile_mp: RTL

Parametrised multi-port register file with an integrated pending-write scoreboard, replacing the single-write, dual-read register bank in the processor datapath. It provides NRD combinational read ports, NWR prioritised write ports, optional same-cycle write-to-read bypass and an optional hardwired-zero register 0. A per-register pending bit is set when an instruction reserving a destination issues and cleared on writeback, giving the issue logic its hazard information.

---
 rtl/regfile_mp.sv | 95 +++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register pending (scoreboard) bits.
// Reads are combinational with optional same-cycle write bypass; register 0 may be hardwired to zero.
module regfile_mp #(
    parameter int AWIDTH   = 5,
    parameter int DWIDTH   = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NRD*AWIDTH-1:0]   raddr,
    output logic [NRD*DWIDTH-1:0]   rdata,
    output logic [NRD-1:0]          rpend,
    input  logic [NWR-1:0]          wen,
    input  logic [NWR*AWIDTH-1:0]   waddr,
    input  logic [NWR*DWIDTH-1:0]   wdata,
    input  logic                    rsv_en,
    input  logic [AWIDTH-1:0]       rsv_addr,
    output logic                    any_pend
);

    localparam int   DEPTH  = 1 << AWIDTH;
    localparam logic BYP_EN = (BYPASS != 32'sd0);
    localparam logic ZR_EN  = (ZERO_REG != 32'sd0);

    logic [DWIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  pend_r;

    logic [AWIDTH-1:0] ra_s    [NRD];
    logic              hit_s   [NRD];
    logic [DWIDTH-1:0] byp_d_s [NRD];
    logic [NRD*DWIDTH-1:0] rdata_s;
    logic [NRD-1:0]        rpend_s;

    function automatic logic zmask(input logic [AWIDTH-1:0] a);
        return ZR_EN && (a == {AWIDTH{1'b0}});
    endfunction

    // Storage and scoreboard update; later ports override earlier ones, reservation overrides clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= '0;
            end
            pend_r <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && !zmask(waddr[j*AWIDTH +: AWIDTH])) begin
                    mem_r[waddr[j*AWIDTH +: AWIDTH]]  <= wdata[j*DWIDTH +: DWIDTH];
                    pend_r[waddr[j*AWIDTH +: AWIDTH]] <= 1'b0;
                end
            end
            if (rsv_en && !zmask(rsv_addr)) begin
                pend_r[rsv_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports with optional write-to-read forwarding.
    always_comb begin
        rdata_s = '0;
        rpend_s = '0;
        for (int i = 0; i < NRD; i++) begin
            ra_s[i]    = raddr[i*AWIDTH +: AWIDTH];
            hit_s[i]   = 1'b0;
            byp_d_s[i] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (BYP_EN && wen[j] && (waddr[j*AWIDTH +: AWIDTH] == ra_s[i])) begin
                    hit_s[i]   = 1'b1;
                    byp_d_s[i] = wdata[j*DWIDTH +: DWIDTH];
                end else begin
                    hit_s[i]   = hit_s[i];
                    byp_d_s[i] = byp_d_s[i];
                end
            end
            if (zmask(ra_s[i])) begin
                rdata_s[i*DWIDTH +: DWIDTH] = '0;
                rpend_s[i]                  = 1'b0;
            end else if (hit_s[i]) begin
                rdata_s[i*DWIDTH +: DWIDTH] = byp_d_s[i];
                rpend_s[i]                  = rsv_en && (rsv_addr == ra_s[i]);
            end else begin
                rdata_s[i*DWIDTH +: DWIDTH] = mem_r[ra_s[i]];
                rpend_s[i]                  = pend_r[ra_s[i]];
            end
        end
    end

    assign rdata    = rdata_s;
    assign rpend    = rpend_s;
    assign any_pend = |pend_r;

endmodule
